// File: rtl/div_ctrl.sv
// Sequencing controller for the 16-bit repeated-subtraction divider.
// Ports: clk, rst (async active-low), btn, s[1:0] in; datapath strobes/selects, busy/done/err, quot out.
module div_ctrl #(
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic [1:0]    s,
  output logic          remld,
  output logic          divld,
  output logic          resld,
  output logic          nbuf,
  output logic          rembuf,
  output logic [1:0]    zc,
  output logic [1:0]    sc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [QW-1:0] quot
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD_N,
    ARM_D,
    LOAD_D,
    ZCHK,
    CMP,
    SUB,
    FIN,
    DONE,
    ERR
  } state_e;

  state_e state_q, state_d;
  logic   btn_q;
  logic   rise;

  logic          remld_q, remld_d;
  logic          divld_q, divld_d;
  logic          resld_q, resld_d;
  logic          nbuf_q, nbuf_d;
  logic          rembuf_q, rembuf_d;
  logic [1:0]    zc_q, zc_d;
  logic [1:0]    sc_q, sc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [QW-1:0] quot_q, quot_d;

  assign rise = btn & ~btn_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = LOAD_N;
      LOAD_N:  state_d = ARM_D;
      ARM_D:   if (rise) state_d = LOAD_D;
      LOAD_D:  state_d = ZCHK;
      ZCHK:    state_d = s[0] ? ERR : CMP;
      CMP:     state_d = s[1] ? FIN : SUB;
      SUB:     state_d = CMP;
      FIN:     state_d = DONE;
      DONE:    if (rise) state_d = IDLE;
      ERR:     if (rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    quot_d = quot_q;
    unique case (state_q)
      LOAD_D:  quot_d = '0;
      SUB:     quot_d = quot_q + QW'(1);
      default: quot_d = quot_q;
    endcase
  end

  // Outputs are decoded from the next state and registered
  // alongside it, so they are pure functions of state_q.
  always_comb begin
    remld_d  = 1'b0;
    divld_d  = 1'b0;
    resld_d  = 1'b0;
    nbuf_d   = 1'b0;
    rembuf_d = 1'b0;
    zc_d     = 2'b00;
    sc_d     = 2'b00;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_d)
      IDLE: busy_d = 1'b0;
      LOAD_N: begin
        remld_d = 1'b1;
        nbuf_d  = 1'b1;
      end
      ARM_D: ;
      LOAD_D: divld_d = 1'b1;
      ZCHK: begin
        zc_d = 2'b10;
        sc_d = 2'b01;
      end
      CMP: begin
        rembuf_d = 1'b1;
        zc_d     = 2'b01;
        sc_d     = 2'b01;
      end
      SUB: begin
        rembuf_d = 1'b1;
        zc_d     = 2'b01;
        remld_d  = 1'b1;
      end
      FIN: resld_d = 1'b1;
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      ERR: begin
        busy_d = 1'b0;
        err_d  = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // btn_q resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      btn_q    <= 1'b1;
      quot_q   <= '0;
      remld_q  <= 1'b0;
      divld_q  <= 1'b0;
      resld_q  <= 1'b0;
      nbuf_q   <= 1'b0;
      rembuf_q <= 1'b0;
      zc_q     <= 2'b00;
      sc_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn;
      quot_q   <= quot_d;
      remld_q  <= remld_d;
      divld_q  <= divld_d;
      resld_q  <= resld_d;
      nbuf_q   <= nbuf_d;
      rembuf_q <= rembuf_d;
      zc_q     <= zc_d;
      sc_q     <= sc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign remld  = remld_q;
  assign divld  = divld_q;
  assign resld  = resld_q;
  assign nbuf   = nbuf_q;
  assign rembuf = rembuf_q;
  assign zc     = zc_q;
  assign sc     = sc_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign quot   = quot_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a small datapath model around it.
// Expected quotient/remainder/timing come from plain N/D arithmetic.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b1;
  logic [1:0]  s;
  logic        remld, divld, resld, nbuf, rembuf;
  logic [1:0]  zc, sc;
  logic        busy, done, err;
  logic [15:0] quot;

  logic [15:0] sw = '0;
  logic [15:0] rem = '0;
  logic [15:0] divr = '0;
  logic [15:0] x, z;

  int checks = 0;
  int errors = 0;
  int n_remld = 0;
  int n_resld = 0;
  int n_sub = 0;
  int n_ovl = 0;

  div_ctrl #(.QW(16)) dut (
    .clk(clk), .rst(rst), .btn(btn), .s(s),
    .remld(remld), .divld(divld), .resld(resld),
    .nbuf(nbuf), .rembuf(rembuf), .zc(zc), .sc(sc),
    .busy(busy), .done(done), .err(err), .quot(quot)
  );

  always #5 clk = ~clk;

  // Datapath: operand mux, ALU, status, registers.
  always_comb begin
    x = nbuf ? sw : (rembuf ? rem : 16'h0);
    case (zc)
      2'b00:   z = x;
      2'b01:   z = x - divr;
      2'b10:   z = divr;
      default: z = 16'h0;
    endcase
    if (sc == 2'b01)
      s = {(zc == 2'b01) && (x < divr), z == 16'h0};
    else
      s = 2'b00;
  end

  always @(posedge clk) begin
    if (remld) rem <= z;
    if (divld) divr <= sw;
  end

  // Per-cycle event counters (count the cycle ending at this edge).
  always @(posedge clk) begin
    if (remld) n_remld++;
    if (resld) n_resld++;
    if (remld && rembuf) n_sub++;
    if ((remld && divld) || (resld && (remld || divld))) n_ovl++;
  end

  function automatic logic [31:0] outs();
    return {remld, divld, resld, nbuf, rembuf, zc, sc,
            busy, done, err, quot};
  endfunction

  task automatic run_div(input logic [15:0] n, input logic [15:0] d,
                         input bit noise, input string tag);
    int eq, er, ecyc, cyc, r0, l0, s0, o0;
    bit fin;
    eq   = (d == 0) ? 0 : int'(n) / int'(d);
    er   = (d == 0) ? 0 : int'(n) % int'(d);
    ecyc = (d == 0) ? 2 : 2 * eq + 4;
    @(negedge clk);
    r0 = n_remld; l0 = n_resld; s0 = n_sub; o0 = n_ovl;
    sw = n;
    btn = 1'b1;
    @(negedge clk);
    checks++;
    if (!(remld === 1'b1 && nbuf === 1'b1 && busy === 1'b1)) begin
      errors++;
      $display("FAIL %s load_n remld=%b nbuf=%b busy=%b required 1 1 1",
               tag, remld, nbuf, busy);
    end
    btn = 1'b0;
    @(negedge clk);
    checks++;
    if (!(busy === 1'b1 && remld === 1'b0 && divld === 1'b0)) begin
      errors++;
      $display("FAIL %s arm_d busy=%b remld=%b divld=%b required 1 0 0",
               tag, busy, remld, divld);
    end
    sw = d;
    btn = 1'b1;
    @(negedge clk);
    checks++;
    if (divld !== 1'b1) begin
      errors++;
      $display("FAIL %s load_d divld=%b required 1", tag, divld);
    end
    btn = 1'b0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < ecyc + 20) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1 || err === 1'b1) fin = 1'b1;
      else if (noise && cyc < 2 * eq) btn = 1'($urandom % 2);
      else btn = 1'b0;
      if (noise) sw = 16'($urandom);
    end
    btn = 1'b0;
    checks++;
    if (!fin || cyc != ecyc) begin
      errors++;
      $display("FAIL %s latency got=%0d fin=%0b required %0d",
               tag, cyc, fin, ecyc);
    end
    checks++;
    if (done !== (d != 0) || err !== (d == 0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s flags done=%b err=%b busy=%b required %b %b 0",
               tag, done, err, busy, d != 0, d == 0);
    end
    checks++;
    if (quot !== 16'(eq)) begin
      errors++;
      $display("FAIL %s quot got=%0d required %0d", tag, quot, eq);
    end
    if (d != 0) begin
      checks++;
      if (rem !== 16'(er)) begin
        errors++;
        $display("FAIL %s remainder got=%0d required %0d", tag, rem, er);
      end
    end
    checks++;
    if (n_remld - r0 != eq + 1 || n_sub - s0 != eq) begin
      errors++;
      $display("FAIL %s pulses remld=%0d sub=%0d required %0d %0d",
               tag, n_remld - r0, n_sub - s0, eq + 1, eq);
    end
    checks++;
    if (n_resld - l0 != ((d == 0) ? 0 : 1) || n_ovl != o0) begin
      errors++;
      $display("FAIL %s resld=%0d overlap=%0d required %0d 0",
               tag, n_resld - l0, n_ovl - o0, (d == 0) ? 0 : 1);
    end
    @(negedge clk);
    checks++;
    if (quot !== 16'(eq) || (done | err) !== 1'b1) begin
      errors++;
      $display("FAIL %s hold quot=%0d done=%b err=%b required %0d",
               tag, quot, done, err, eq);
    end
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ack done=%b err=%b busy=%b required 0 0 0",
               tag, done, err, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn = 1'b1;
    #1;
    checks++;
    if (outs() !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs got=%h required 0", outs());
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 32'h0) begin
      errors++;
      $display("FAIL reset_held_btn got=%h required 0", outs());
    end
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    checks++;
    if (remld !== 1'b1 || nbuf !== 1'b1) begin
      errors++;
      $display("FAIL reset_press remld=%b nbuf=%b required 1 1",
               remld, nbuf);
    end
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_div(16'd17, 16'd5, 1'b0, "div17_5");
    run_div(16'd3, 16'd7, 1'b0, "n_lt_d");
    run_div(16'd5, 16'd5, 1'b0, "n_eq_d");
    run_div(16'd0, 16'd9, 1'b0, "n_zero");
  endtask

  task automatic test_div_zero();
    run_div(16'd1234, 16'd0, 1'b0, "divzero");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_div(16'($urandom_range(0, 700)), 16'($urandom_range(1, 40)),
              1'b0, "random");
  endtask

  task automatic test_large();
    run_div(16'd4000, 16'd1, 1'b0, "large");
    run_div(16'hFFFF, 16'h8000, 1'b0, "big_ops");
  endtask

  task automatic test_ignore_presses();
    run_div(16'd200, 16'd3, 1'b1, "noise");
  endtask

  task automatic test_reset_midloop();
    @(negedge clk);
    sw = 16'd1000;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    sw = 16'd1;
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midloop_busy got=%b required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 32'h0) begin
      errors++;
      $display("FAIL midloop_async got=%h required 0", outs());
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || resld !== 1'b0) begin
      errors++;
      $display("FAIL midloop_idle busy=%b done=%b resld=%b required 0",
               busy, done, resld);
    end
    run_div(16'd50, 16'd6, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_random();
    test_large();
    test_ignore_presses();
    test_reset_midloop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the 16-bit repeated-subtraction divider. It sits directly upstream of the divider datapath and drives all of its load strobes, operand-buffer selects and ALU/status selects. It consumes the datapath's 2-bit status and steps through operand entry from the switches, a divide-by-zero check, and the subtract loop. It also counts subtractions to produce the quotient and reports done/error to the board-level wrapper.

## Interface
- QW, 16: quotient counter width.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn  in  1  debounced load/acknowledge button, level.
- s  in  2  datapath status, combinational from current controls: s[1] = ALU result negative (x<y for SUB), s[0] = ALU result zero.
- remld  out  1  load remainder register from ALU result z.
- divld  out  1  load divisor register from switches.
- resld  out  1  load result flag register.
- nbuf  out  1  select N onto ALU x.
- rembuf  out  1  select remainder onto ALU x.
- zc  out  2  ALU op: 00 PASS x, 01 SUB x−y, 10 PASS y, 11 unused (never driven).
- sc  out  2  status select: 00 hold/ignore, 01 update s from current z.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  high in DONE.
- err  out  1  high in ERR (divide by zero).
- quot  out  QW  quotient, valid while done=1.

## Operation
- Button edge: btn_q registered copy of btn; rise = btn & ~btn_q. btn_q resets to 1, so a button held through reset release is not a press.
- All datapath controls and flags are Moore outputs, decoded from state only. Control values not listed for a state are 0.
- IDLE: waits for rise, then goes to LOAD_N.
- LOAD_N (1 cycle): remld=1, nbuf=1, zc=00, then ARM_D.
  - Effect: N is captured from the switches and copied to the remainder.
- ARM_D: busy=1. Waits for rise, then goes to LOAD_D.
- LOAD_D (1 cycle): divld=1, then ZCHK. quot cleared to 0 in this cycle.
- ZCHK (1 cycle): zc=10, sc=01.
  - s[0]=1 → ERR.
  - Otherwise → CMP.
- CMP (1 cycle): rembuf=1, zc=01, sc=01.
  - s[1]=1 → FIN.
  - Otherwise → SUB.
- SUB (1 cycle): rembuf=1, zc=01, remld=1, quot ← quot+1, then CMP.
- FIN (1 cycle): resld=1, then DONE.
- DONE: done=1, quot held. A rise goes to IDLE.
- ERR: err=1, quot=0. A rise goes to IDLE.
- rise is ignored in LOAD_N, LOAD_D, ZCHK, CMP, SUB and FIN.
- Arithmetic: unsigned 16-bit. With divisor ≥1, quot ≤ 65535, so the QW=16 counter cannot wrap. No saturation logic is needed.
- Remainder ends in the datapath remainder register. The controller does not hold it.
- s is sampled in the same cycle the controls are driven. The path is combinational through the datapath ALU and must close in one clk period.

## Timing
- Reset (async assert, any state): state=IDLE, btn_q=1, quot=0, all outputs 0. Outputs go low immediately on assertion, not at the next edge.
- Reset during the loop abandons the operation. No partial result is flagged.
- Press latency: a rise seen at edge k puts the block in LOAD_N (or LOAD_D) during cycle k+1.
- Iteration: each subtraction takes 2 cycles (CMP+SUB).
- From LOAD_D entry to DONE entry: 2q+4 cycles, for quotient q.
- Divide by zero: ERR is entered 2 cycles after LOAD_D entry.
- resld is exactly 1 cycle wide and is never asserted together with remld or divld.
- remld and divld are never high in the same cycle.

## Test plan
- Reset: hold rst=0 with btn=1, release, keep btn=1 → stays IDLE, all outputs 0. Release btn, press → LOAD_N.
- 17 ÷ 5: press (N=17), press (D=5).
  - Required: remld pulses 1 (load) + 3 (SUB); done asserted 10 cycles after LOAD_D; quot=3; datapath remainder=2; resld one pulse.
- N<D (3 ÷ 7): first CMP sees s[1]=1 → DONE 4 cycles after LOAD_D, quot=0, no SUB.
- Divide by zero (D=0): ERR 2 cycles after LOAD_D, err=1, quot=0, no SUB. The next press → IDLE.
- Max quotient (65535 ÷ 1): quot=16'hFFFF, done after 131074 cycles, no wrap.
- Presses ignored mid-loop: toggle btn during CMP/SUB → no state disturbance. Assert rst mid-loop → all outputs 0 asynchronously, IDLE after release.
